// File: rtl/bnn_weight_streamer.sv
// Host-side transmitter for the BNN weight-load protocol: holds a byte-wise
// writable weight image and replays it as a lo/hi nibble stream on start.
module bnn_weight_streamer #(
    parameter int NUM_NEURONS = 12,
    parameter int ADDR_W      = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [7:0]        i_wr_data,
    input  logic              i_start,
    input  logic              i_hold,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_load_en,
    output logic [3:0]        o_nibble,
    output logic [1:0]        o_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);
    localparam logic [ADDR_W:0]   NUM_EXT  = (ADDR_W + 1)'(NUM_NEURONS);

    state_t            r_state;
    logic [ADDR_W-1:0] r_idx;
    logic              r_busy;
    logic              r_done;
    logic [7:0]        r_buf [NUM_NEURONS];

    logic              w_addr_ok;
    logic              w_wr_ok;
    logic [7:0]        w_cur;

    // Power-on image; matches the BNN core's own reset weights.
    function automatic logic [7:0] default_weight(input int idx);
        case (idx)
            0:       default_weight = 8'hE0;
            1:       default_weight = 8'h70;
            2:       default_weight = 8'h38;
            3:       default_weight = 8'h1C;
            4:       default_weight = 8'h0E;
            5:       default_weight = 8'h07;
            6:       default_weight = 8'hFF;
            7:       default_weight = 8'h00;
            8:       default_weight = 8'hC0;
            9:       default_weight = 8'h30;
            10:      default_weight = 8'h0C;
            11:      default_weight = 8'h80;
            default: default_weight = 8'h00;
        endcase
    endfunction

    // The image is frozen while streaming so the BNN sees one consistent set.
    assign w_addr_ok = ({1'b0, i_wr_addr} < NUM_EXT);
    assign w_wr_ok   = i_wr_en && w_addr_ok &&
                       ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                r_buf[i] <= default_weight(i);
            end
        end else begin
            if (w_wr_ok) begin
                r_buf[i_wr_addr] <= i_wr_data;
            end
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_LO;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_LO: begin
                    if (!i_hold) begin
                        r_state <= S_HI;
                    end
                end
                S_HI: begin
                    if (!i_hold) begin
                        if (r_idx == LAST_IDX) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_LO;
                            r_idx   <= r_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // A write landing on the start edge is already in r_buf by the first LO cycle.
    assign w_cur = r_buf[r_idx];

    always_comb begin
        o_nibble = 4'h0;
        case (r_state)
            S_LO:    o_nibble = w_cur[3:0];
            S_HI:    o_nibble = w_cur[7:4];
            default: o_nibble = 4'h0;
        endcase
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_load_en = r_busy & ~i_hold;
    assign o_state   = r_state;

endmodule
